ptw_mem_arbiter: RTL

- Sits directly downstream of the instruction-side and data-side Sv32 MMUs and owns their page-table-walk (PTW) memory ports.
- Arbitrates the two PTW read requests round-robin and issues each granted request as a single Wishbone classic read on a dedicated bus master port.
- Returns the PTE word with a one-cycle ack pulse to the requesting MMU.
- Converts bus errors and bus timeouts into an all-zero PTE (V=0), so the MMU raises a page fault instead of hanging.

---
 rtl/ptw_mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter
// Shares one Wishbone classic read master between the instruction-side and
// data-side Sv32 MMU page-table walkers. Requests are granted round-robin.
// Each grant becomes exactly one bus read, and the PTE goes back to the MMU
// that asked for it. A bus error or a bus that never answers comes back as an
// all-zero PTE (V=0). The walker then takes a page fault instead of stalling.

module ptw_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ptw0_req_i,
    input  logic [31:0] ptw0_addr_i,
    output logic [31:0] ptw0_data_o,
    output logic        ptw0_ack_o,

    input  logic        ptw1_req_i,
    input  logic [31:0] ptw1_addr_i,
    output logic [31:0] ptw1_data_o,
    output logic        ptw1_ack_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,

    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The last BUS cycle before giving up is TIMEOUT_CYCLES-1.
    // When TIMEOUT_CYCLES is zero, the timeout is switched off entirely.
    localparam bit          TO_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST   = TO_ENABLE ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      r_state;
    logic        r_lastGrant;
    logic        r_grant;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_err;
    logic [15:0] r_count;

    logic        w_anyReq;
    logic        w_pick1;
    logic [31:0] w_selAddr;
    logic        w_timeout;

    // If only port 1 is requesting, port 1 wins.
    // If both ports request, port 1 wins only when port 0 had the last grant.
    assign w_anyReq  = ptw0_req_i | ptw1_req_i;
    assign w_pick1   = ptw1_req_i & (~ptw0_req_i | ~r_lastGrant);
    assign w_selAddr = w_pick1 ? ptw1_addr_i : ptw0_addr_i;
    assign w_timeout = TO_ENABLE && (r_count == TO_LAST);

    // Walk IDLE -> BUS -> RESP, latching the grant, the address and the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_grant     <= 1'b0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_err       <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant <= w_pick1;
                        r_addr  <= w_selAddr & 32'hFFFF_FFFC;
                        r_count <= 16'd0;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (wb_err_i) begin
                        r_data  <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else if (wb_ack_i) begin
                        r_data  <= wb_dat_i;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else begin
                        r_count <= r_count + 16'd1;
                        if (w_timeout) begin
                            r_data  <= 32'd0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_lastGrant <= r_grant;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The bus strobes and response strobes are decoded purely from the
    // registered state. Because of that, the asynchronous reset removes them
    // at once, without waiting for a clock edge.
    assign wb_cyc_o    = (r_state == BUS);
    assign wb_stb_o    = (r_state == BUS);
    assign wb_we_o     = 1'b0;
    assign wb_sel_o    = 4'b1111;
    assign wb_adr_o    = r_addr;
    assign wb_dat_o    = 32'd0;

    assign ptw0_data_o = r_data;
    assign ptw1_data_o = r_data;
    assign ptw0_ack_o  = (r_state == RESP) & ~r_grant;
    assign ptw1_ack_o  = (r_state == RESP) &  r_grant;

    assign busy_o      = (r_state != IDLE);
    assign err_o       = (r_state == RESP) & r_err;

endmodule
